csr_requester: RTL and testbench

CSR_REQUESTER -- requirements
Module: csr_requester

---
 rtl/csr_requester_if.sv | 54 +++++
 rtl/csr_requester.sv | 153 +++++++++++++++
 tb/tb_csr_requester.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_requester_if.sv
// Shared CSR/trap types and the requester-to-CSR-unit bus.
package riscv_defines;

  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_mode_t;

  typedef enum logic [1:0] {
    TRAP_NONE   = 2'd0,
    TRAP_ENTER  = 2'd1,
    TRAP_RETURN = 2'd2
  } trap_mode_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef struct packed {
    logic        valid;
    logic [11:0] csr_target;
    csr_mode_t   csr_mode;
  } csr_req_t;

  typedef struct packed {
    trap_mode_t  mode;
    logic [30:0] cause;
    logic [31:0] pc;
    logic [31:0] tval;
  } trap_req_t;

endpackage

// Request/trap channel between the requester and the CSR unit.
interface csr_interface;
  riscv_defines::csr_req_t  req;
  logic [31:0]              wdata;
  riscv_defines::trap_req_t trap;
  logic [31:0]              rdata;

  modport requester (output req, output wdata, output trap, input rdata);
  modport responder (input req, input wdata, input trap, output rdata);
endinterface

// File: rtl/csr_requester.sv
// Sequences CSR accesses, exception entry and MRET toward the CSR unit,
// returning old CSR values and issuing fetch redirects.
module csr_requester (
  input  logic                     clk,
  input  logic                     start,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_kind,
  input  logic [11:0]              cmd_csr_addr,
  input  riscv_defines::csr_mode_t cmd_csr_mode,
  input  logic [31:0]              cmd_operand,
  input  logic [31:0]              cmd_pc,
  input  logic [30:0]              cmd_cause,
  input  logic [31:0]              cmd_tval,
  input  logic [31:0]              mtvec_i,
  input  logic [31:0]              mepc_i,
  csr_interface.requester          csr_bus,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc
);

  typedef enum logic [2:0] {
    IDLE,
    CSR_REQ,
    CSR_RSP,
    TRAP_ENTER,
    TRAP_RET,
    REDIRECT
  } state_t;

  localparam logic [30:0] CAUSE_ILLEGAL = 31'd2;

  state_t                   state_reg, state_next;
  logic [11:0]              addr_reg;
  riscv_defines::csr_mode_t mode_reg;
  logic [31:0]              operand_reg;
  logic [31:0]              pc_reg;
  logic [30:0]              cause_reg;
  logic [31:0]              tval_reg;
  logic [31:0]              rdata_reg;
  logic [31:0]              redirect_pc_reg;

  logic                     req_valid;
  riscv_defines::trap_mode_t trap_mode;
  logic                     accept;
  logic                     addr_supported;

  // Decode whether the offered address is an implemented machine CSR.
  always_comb begin
    case (cmd_csr_addr)
      riscv_defines::CSR_MSTATUS, riscv_defines::CSR_MTVEC,
      riscv_defines::CSR_MIE,     riscv_defines::CSR_MIP,
      riscv_defines::CSR_MEPC,    riscv_defines::CSR_MCAUSE,
      riscv_defines::CSR_MTVAL,   riscv_defines::CSR_MHARTID,
      riscv_defines::CSR_MSCRATCH: addr_supported = 1'b1;
      default:                     addr_supported = 1'b0;
    endcase
  end

  assign accept = cmd_valid && (state_reg == IDLE);

  // State register; reset aborts any in-flight operation immediately.
  always_ff @(posedge clk or negedge start) begin
    if (!start) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state selection and per-state output pulses, all decoded from state.
  always_comb begin
    state_next     = state_reg;
    cmd_ready      = 1'b0;
    req_valid      = 1'b0;
    trap_mode      = riscv_defines::TRAP_NONE;
    rsp_valid      = 1'b0;
    redirect_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_kind)
            2'd0:    state_next = addr_supported ? CSR_REQ : TRAP_ENTER;
            2'd1:    state_next = TRAP_ENTER;
            2'd2:    state_next = TRAP_RET;
            default: state_next = IDLE;
          endcase
        end
      end
      CSR_REQ: begin
        req_valid  = 1'b1;
        state_next = CSR_RSP;
      end
      CSR_RSP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      TRAP_ENTER: begin
        trap_mode  = riscv_defines::TRAP_ENTER;
        state_next = REDIRECT;
      end
      TRAP_RET: begin
        trap_mode  = riscv_defines::TRAP_RETURN;
        state_next = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command capture on acceptance, CSR read data and redirect target capture.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      addr_reg        <= '0;
      mode_reg        <= riscv_defines::CSR_NONE;
      operand_reg     <= '0;
      pc_reg          <= '0;
      cause_reg       <= '0;
      tval_reg        <= '0;
      rdata_reg       <= '0;
      redirect_pc_reg <= '0;
    end else begin
      if (accept) begin
        addr_reg    <= cmd_csr_addr;
        mode_reg    <= cmd_csr_mode;
        operand_reg <= cmd_operand;
        pc_reg      <= cmd_pc;
        // A CSR access only reaches TRAP_ENTER when its address is unsupported.
        if (cmd_kind == 2'd0) begin
          cause_reg <= CAUSE_ILLEGAL;
          tval_reg  <= '0;
        end else begin
          cause_reg <= cmd_cause;
          tval_reg  <= cmd_tval;
        end
      end
      if (state_reg == CSR_REQ) rdata_reg <= csr_bus.rdata;
      // Trap vector is forced to direct mode by clearing the low two bits.
      if (state_reg == TRAP_ENTER) redirect_pc_reg <= mtvec_i & 32'hFFFF_FFFC;
      if (state_reg == TRAP_RET)   redirect_pc_reg <= mepc_i;
    end
  end

  assign csr_bus.req   = '{valid: req_valid, csr_target: addr_reg, csr_mode: mode_reg};
  assign csr_bus.wdata = operand_reg;
  assign csr_bus.trap  = '{mode: trap_mode, cause: cause_reg, pc: pc_reg, tval: tval_reg};
  assign rsp_rdata     = rdata_reg;
  assign redirect_pc   = redirect_pc_reg;

endmodule

// File: tb/tb_csr_requester.sv
// Directed bench for csr_requester.
module tb_csr_requester;

  logic                     clk = 1'b0;
  logic                     start;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_kind;
  logic [11:0]              cmd_csr_addr;
  riscv_defines::csr_mode_t cmd_csr_mode;
  logic [31:0]              cmd_operand;
  logic [31:0]              cmd_pc;
  logic [30:0]              cmd_cause;
  logic [31:0]              cmd_tval;
  logic [31:0]              mtvec_i;
  logic [31:0]              mepc_i;
  logic                     rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;

  int errors = 0;
  int checks = 0;
  int req_pulses = 0;
  int redir_pulses = 0;
  int base_req;
  int base_redir;

  csr_interface bus ();

  csr_requester dut (
    .clk            (clk),
    .start          (start),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_kind       (cmd_kind),
    .cmd_csr_addr   (cmd_csr_addr),
    .cmd_csr_mode   (cmd_csr_mode),
    .cmd_operand    (cmd_operand),
    .cmd_pc         (cmd_pc),
    .cmd_cause      (cmd_cause),
    .cmd_tval       (cmd_tval),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .csr_bus        (bus),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  // Count request and redirect cycles to catch lost or duplicated pulses.
  always @(posedge clk) begin
    if (bus.req.valid) req_pulses++;
    if (redirect_valid) redir_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] kind, input logic [11:0] addr,
                       input riscv_defines::csr_mode_t mode, input logic [31:0] operand,
                       input logic [31:0] pc, input logic [30:0] cause, input logic [31:0] tval);
    cmd_valid    = 1'b1;
    cmd_kind     = kind;
    cmd_csr_addr = addr;
    cmd_csr_mode = mode;
    cmd_operand  = operand;
    cmd_pc       = pc;
    cmd_cause    = cause;
    cmd_tval     = tval;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req_valid"}, {31'd0, bus.req.valid}, 32'd0);
    chk({tag, "_trap_mode"}, {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_NONE});
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    start        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_kind     = 2'd3;
    cmd_csr_addr = '0;
    cmd_csr_mode = riscv_defines::CSR_RW;
    cmd_operand  = '0;
    cmd_pc       = '0;
    cmd_cause    = '0;
    cmd_tval     = '0;
    mtvec_i      = '0;
    mepc_i       = '0;
    bus.rdata    = '0;

    // Reset state
    #2;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk_quiet("rst");
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_csr_target", {20'd0, bus.req.csr_target}, 32'd0);
    chk("rst_trap_cause", {1'b0, bus.trap.cause}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b1;
    step();
    $display("txn reset: done");

    // CSR_RS on MSCRATCH
    offer(2'd0, 12'h340, riscv_defines::CSR_RS, 32'h0F, 32'h0, 31'd0, 32'h0);
    bus.rdata = 32'hA0;
    chk("csr_ready_c0", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    chk("csr_req_valid_c1", {31'd0, bus.req.valid}, 32'd1);
    chk("csr_target_c1", {20'd0, bus.req.csr_target}, 32'h340);
    chk("csr_mode_c1", {29'd0, bus.req.csr_mode}, {29'd0, riscv_defines::CSR_RS});
    chk("csr_wdata_c1", bus.wdata, 32'h0F);
    chk("csr_trap_none_c1", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_NONE});
    chk("csr_ready_c1", {31'd0, cmd_ready}, 32'd0);
    step();
    bus.rdata = 32'h0;
    chk("csr_rsp_valid_c2", {31'd0, rsp_valid}, 32'd1);
    chk("csr_rsp_rdata_c2", rsp_rdata, 32'hA0);
    chk("csr_req_valid_c2", {31'd0, bus.req.valid}, 32'd0);
    step();
    chk("csr_ready_c3", {31'd0, cmd_ready}, 32'd1);
    chk_quiet("csr_c3");
    $display("txn csr_rs mscratch: rdata=0x%08h", rsp_rdata);

    // Exception
    base_req = req_pulses;
    mtvec_i = 32'h8000_0001;
    offer(2'd1, 12'h0, riscv_defines::CSR_RW, 32'h0, 32'h104, 31'd5, 32'h55);
    step();
    cmd_valid = 1'b0;
    chk("exc_trap_mode", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_ENTER});
    chk("exc_cause", {1'b0, bus.trap.cause}, 32'd5);
    chk("exc_pc", bus.trap.pc, 32'h104);
    chk("exc_tval", bus.trap.tval, 32'h55);
    chk("exc_req_valid", {31'd0, bus.req.valid}, 32'd0);
    step();
    chk("exc_trap_once", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_NONE});
    chk("exc_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("exc_redirect_pc", redirect_pc, 32'h8000_0000);
    step();
    chk("exc_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk_quiet("exc_end");
    chk("exc_no_req", req_pulses - base_req, 32'd0);
    $display("txn exception: redirect_pc=0x%08h", redirect_pc);

    // MRET
    base_req = req_pulses;
    mepc_i = 32'h200;
    offer(2'd2, 12'h0, riscv_defines::CSR_RW, 32'h0, 32'h400, 31'd0, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("mret_trap_mode", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_RETURN});
    chk("mret_req_valid", {31'd0, bus.req.valid}, 32'd0);
    step();
    chk("mret_trap_once", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_NONE});
    chk("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("mret_redirect_pc", redirect_pc, 32'h200);
    step();
    chk_quiet("mret_end");
    chk("mret_no_req", req_pulses - base_req, 32'd0);
    $display("txn mret: redirect_pc=0x%08h", redirect_pc);

    // Unsupported CSR address
    base_req = req_pulses;
    mtvec_i = 32'h0000_1000;
    offer(2'd0, 12'h7C0, riscv_defines::CSR_RW, 32'h1234, 32'h300, 31'd9, 32'hDEAD);
    step();
    cmd_valid = 1'b0;
    chk("ill_trap_mode", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_ENTER});
    chk("ill_cause", {1'b0, bus.trap.cause}, 32'd2);
    chk("ill_tval", bus.trap.tval, 32'd0);
    chk("ill_pc", bus.trap.pc, 32'h300);
    chk("ill_req_valid", {31'd0, bus.req.valid}, 32'd0);
    step();
    chk("ill_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("ill_redirect_pc", redirect_pc, 32'h1000);
    step();
    chk("ill_no_req", req_pulses - base_req, 32'd0);
    $display("txn illegal csr 0x7c0: cause=2");

    // No-op
    offer(2'd3, 12'h300, riscv_defines::CSR_RW, 32'h0, 32'h0, 31'd0, 32'h0);
    step();
    cmd_valid = 1'b0;
    chk("nop_ready", {31'd0, cmd_ready}, 32'd1);
    chk_quiet("nop");
    $display("txn nop");

    // Back-to-back commands held on cmd_valid
    base_req = req_pulses;
    offer(2'd0, 12'hF14, riscv_defines::CSR_RS, 32'h0, 32'h0, 31'd0, 32'h0);
    bus.rdata = 32'h11;
    step();
    offer(2'd0, 12'h300, riscv_defines::CSR_RW, 32'h8, 32'h0, 31'd0, 32'h0);
    chk("b2b_first_target", {20'd0, bus.req.csr_target}, 32'hF14);
    chk("b2b_busy", {31'd0, cmd_ready}, 32'd0);
    step();
    bus.rdata = 32'h22;
    chk("b2b_first_rsp", rsp_rdata, 32'h11);
    chk("b2b_no_early_req", {31'd0, bus.req.valid}, 32'd0);
    step();
    chk("b2b_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk("b2b_idle_no_req", {31'd0, bus.req.valid}, 32'd0);
    step();
    cmd_valid = 1'b0;
    chk("b2b_second_valid", {31'd0, bus.req.valid}, 32'd1);
    chk("b2b_second_target", {20'd0, bus.req.csr_target}, 32'h300);
    chk("b2b_second_wdata", bus.wdata, 32'h8);
    step();
    chk("b2b_second_rsp", rsp_rdata, 32'h22);
    step();
    step();
    chk("b2b_req_count", req_pulses - base_req, 32'd2);
    $display("txn back-to-back: req pulses=%0d", req_pulses - base_req);

    // Reset during TRAP_ENTER
    bus.rdata = 32'h0;
    mtvec_i = 32'h0000_2000;
    offer(2'd1, 12'h0, riscv_defines::CSR_RW, 32'h0, 32'h500, 31'd7, 32'h77);
    step();
    cmd_valid = 1'b0;
    chk("rmid_trap_before", {30'd0, bus.trap.mode}, {30'd0, riscv_defines::TRAP_ENTER});
    start = 1'b0;
    #1;
    chk_quiet("rmid");
    chk("rmid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rmid_redirect_pc", redirect_pc, 32'd0);
    chk("rmid_rsp_rdata", rsp_rdata, 32'd0);
    chk("rmid_trap_cause", {1'b0, bus.trap.cause}, 32'd0);
    base_redir = redir_pulses;
    step();
    start = 1'b1;
    step();
    step();
    step();
    chk("rmid_no_redirect", redir_pulses - base_redir, 32'd0);
    chk_quiet("rmid_after");
    $display("txn reset mid-trap: redirects=%0d", redir_pulses - base_redir);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
